// File: rtl/com_fw_dut_arbiter_if.sv
// rtl/com_fw_dut_arbiter_if.sv - firmware request/grant and pin-mux enable bundle
interface com_fw_dut_arbiter_if;
  logic [3:0] fw_req;
  logic [3:0] fw_grant;
  logic [3:0] fw_dev_id_enable;

  modport master (
    output fw_req,
    input  fw_grant,
    input  fw_dev_id_enable
  );

  modport slave (
    input  fw_req,
    output fw_grant,
    output fw_dev_id_enable
  );
endinterface

// File: rtl/com_fw_dut_arbiter.sv
// rtl/com_fw_dut_arbiter.sv - round-robin/forced owner arbiter with all-zero guard between owners
module com_fw_dut_arbiter #(
  parameter int GUARD_CYCLES = 16
) (
  input  logic                       iob_clk,
  input  logic                       iob_reset_n,
  com_fw_dut_arbiter_if.slave        pins,
  input  logic                       force_en,
  input  logic [3:0]                 force_dev_id,
  input  logic                       err_clear,
  output logic [1:0]                 arb_state,
  output logic                       err_force_illegal,
  output logic [15:0]                switch_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] owner;
  logic       forced;
  logic [1:0] last_ptr;
  logic [7:0] guard_cnt;

  logic       force_onehot;
  logic [1:0] force_idx;
  logic [1:0] rr_idx;
  logic       owner_req;
  logic       grant_end;

  // First requester strictly after the last owner, wrapping; the last owner is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    onehot_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) onehot_idx = 2'(k);
    end
  endfunction

  assign force_onehot = $onehot(force_dev_id);
  assign force_idx    = onehot_idx(force_dev_id);
  assign rr_idx       = rr_pick(pins.fw_req, last_ptr);
  assign owner_req    = |(pins.fw_req & owner);

  // Forced grants follow the register; arbitrated grants follow the owner's request and yield to force.
  assign grant_end = forced ? !(force_en && (force_dev_id == owner))
                            : (!owner_req || force_en);

  always_ff @(posedge iob_clk or negedge iob_reset_n) begin
    if (!iob_reset_n) begin
      state             <= ST_IDLE;
      owner             <= 4'h0;
      forced            <= 1'b0;
      last_ptr          <= 2'd3;
      guard_cnt         <= 8'd0;
      err_force_illegal <= 1'b0;
      switch_count      <= 16'd0;
    end else begin
      if (err_clear) err_force_illegal <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (force_en) begin
            if (force_onehot) begin
              state        <= ST_GRANT;
              owner        <= force_dev_id;
              forced       <= 1'b1;
              last_ptr     <= force_idx;
              switch_count <= switch_count + 16'd1;
            end else begin
              err_force_illegal <= 1'b1;
            end
          end else if (|pins.fw_req) begin
            state        <= ST_GRANT;
            owner        <= 4'b0001 << rr_idx;
            forced       <= 1'b0;
            last_ptr     <= rr_idx;
            switch_count <= switch_count + 16'd1;
          end
        end

        ST_GRANT: begin
          if (grant_end) begin
            state     <= ST_GUARD;
            owner     <= 4'h0;
            forced    <= 1'b0;
            guard_cnt <= 8'(GUARD_CYCLES - 1);
          end
        end

        ST_GUARD: begin
          if (guard_cnt == 8'd0) begin
            state <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt - 8'd1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          owner  <= 4'h0;
          forced <= 1'b0;
        end
      endcase
    end
  end

  assign pins.fw_dev_id_enable = owner;
  assign pins.fw_grant         = owner;
  assign arb_state             = state;

endmodule

// File: tb/tb_com_fw_dut_arbiter.sv
// tb/tb_com_fw_dut_arbiter.sv - directed self-checking bench for com_fw_dut_arbiter
module tb_com_fw_dut_arbiter;

  logic        iob_clk;
  logic        iob_reset_n;
  logic        force_en;
  logic [3:0]  force_dev_id;
  logic        err_clear;
  logic [1:0]  arb_state;
  logic        err_force_illegal;
  logic [15:0] switch_count;

  int checks;
  int errors;
  int exp_sw;

  com_fw_dut_arbiter_if bus();

  com_fw_dut_arbiter #(.GUARD_CYCLES(16)) dut (
    .iob_clk           (iob_clk),
    .iob_reset_n       (iob_reset_n),
    .pins              (bus),
    .force_en          (force_en),
    .force_dev_id      (force_dev_id),
    .err_clear         (err_clear),
    .arb_state         (arb_state),
    .err_force_illegal (err_force_illegal),
    .switch_count      (switch_count)
  );

  initial iob_clk = 1'b0;
  always #5 iob_clk = ~iob_clk;

  task automatic tick();
    @(posedge iob_clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (arb_state != 2'd0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (arb_state !== 2'd0) begin
      errors++;
      $display("FAIL %s_idle_timeout state=%0d expected=0", name, arb_state);
    end
  endtask

  task automatic test_reset();
    iob_reset_n  = 1'b0;
    bus.fw_req   = 4'h0;
    force_en     = 1'b0;
    force_dev_id = 4'h0;
    err_clear    = 1'b0;
    exp_sw       = 0;
    #12;
    checks++;
    if ({bus.fw_dev_id_enable, bus.fw_grant, arb_state, err_force_illegal, switch_count} !== 27'd0) begin
      errors++;
      $display("FAIL reset_values en=%h gnt=%h st=%0d err=%b cnt=%0d expected all zero",
               bus.fw_dev_id_enable, bus.fw_grant, arb_state, err_force_illegal, switch_count);
    end
    @(negedge iob_clk);
    iob_reset_n = 1'b1;
    tick();
    checks++;
    if (arb_state !== 2'd0 || bus.fw_dev_id_enable !== 4'h0) begin
      errors++;
      $display("FAIL idle_no_req st=%0d en=%h expected st=0 en=0", arb_state, bus.fw_dev_id_enable);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rr_exp [5];
    logic [3:0] own;
    int z;
    rr_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    bus.fw_req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      z = 0;
      while (bus.fw_dev_id_enable == 4'h0 && z < 40) begin
        z++;
        tick();
      end
      own = bus.fw_dev_id_enable;
      exp_sw++;
      checks++;
      if (own !== rr_exp[i] || bus.fw_grant !== rr_exp[i]) begin
        errors++;
        $display("FAIL rr_owner_%0d en=%h gnt=%h expected=%h", i, own, bus.fw_grant, rr_exp[i]);
      end
      if (i > 0) begin
        checks++;
        if (z !== 17) begin
          errors++;
          $display("FAIL rr_gap_%0d zero_cycles=%0d expected=17", i, z);
        end
      end
      if (i < 4) begin
        repeat (9) tick();
        bus.fw_req = 4'hF & ~own;
        tick();
        bus.fw_req = 4'hF;
      end
    end
    checks++;
    if (switch_count !== 16'(exp_sw)) begin
      errors++;
      $display("FAIL rr_switch_count got=%0d expected=%0d", switch_count, exp_sw);
    end
    bus.fw_req = 4'h0;
    tick();
    wait_idle("rr");
  endtask

  task automatic test_single_request();
    bus.fw_req = 4'h4;
    #1;
    checks++;
    if (bus.fw_dev_id_enable !== 4'h0) begin
      errors++;
      $display("FAIL single_no_comb_path en=%h expected=0", bus.fw_dev_id_enable);
    end
    tick();
    exp_sw++;
    checks++;
    if (bus.fw_dev_id_enable !== 4'h4 || bus.fw_grant !== 4'h4 || arb_state !== 2'd1
        || switch_count !== 16'(exp_sw)) begin
      errors++;
      $display("FAIL single_grant en=%h gnt=%h st=%0d cnt=%0d expected en=4 gnt=4 st=1 cnt=%0d",
               bus.fw_dev_id_enable, bus.fw_grant, arb_state, switch_count, exp_sw);
    end
    bus.fw_req = 4'h0;
    tick();
    checks++;
    if (bus.fw_dev_id_enable !== 4'h0 || arb_state !== 2'd2) begin
      errors++;
      $display("FAIL single_release en=%h st=%0d expected en=0 st=2", bus.fw_dev_id_enable, arb_state);
    end
    repeat (15) tick();
    checks++;
    if (arb_state !== 2'd2) begin
      errors++;
      $display("FAIL guard_last_cycle st=%0d expected=2", arb_state);
    end
    tick();
    checks++;
    if (arb_state !== 2'd0) begin
      errors++;
      $display("FAIL guard_exit st=%0d expected=0", arb_state);
    end
  endtask

  task automatic test_force_preempt();
    int z;
    bus.fw_req = 4'h1;
    tick();
    exp_sw++;
    checks++;
    if (bus.fw_dev_id_enable !== 4'h1) begin
      errors++;
      $display("FAIL fp_fw0_grant en=%h expected=1", bus.fw_dev_id_enable);
    end
    force_en     = 1'b1;
    force_dev_id = 4'h8;
    tick();
    checks++;
    if (bus.fw_dev_id_enable !== 4'h0 || arb_state !== 2'd2) begin
      errors++;
      $display("FAIL fp_preempt en=%h st=%0d expected en=0 st=2", bus.fw_dev_id_enable, arb_state);
    end
    z = 0;
    while (bus.fw_dev_id_enable == 4'h0 && z < 40) begin
      z++;
      tick();
    end
    exp_sw++;
    checks++;
    if (bus.fw_dev_id_enable !== 4'h8 || z !== 17) begin
      errors++;
      $display("FAIL fp_forced_owner en=%h gap=%0d expected en=8 gap=17", bus.fw_dev_id_enable, z);
    end
    force_en   = 1'b0;
    bus.fw_req = 4'hF;
    tick();
    checks++;
    if (arb_state !== 2'd2) begin
      errors++;
      $display("FAIL fp_unforce_guard st=%0d expected=2", arb_state);
    end
    z = 0;
    while (bus.fw_dev_id_enable == 4'h0 && z < 40) begin
      z++;
      tick();
    end
    exp_sw++;
    checks++;
    if (bus.fw_dev_id_enable !== 4'h1 || z !== 17) begin
      errors++;
      $display("FAIL fp_resume_fw0 en=%h gap=%0d expected en=1 gap=17", bus.fw_dev_id_enable, z);
    end
    checks++;
    if (switch_count !== 16'(exp_sw)) begin
      errors++;
      $display("FAIL fp_switch_count got=%0d expected=%0d", switch_count, exp_sw);
    end
    bus.fw_req = 4'h0;
    tick();
    wait_idle("fp");
  endtask

  task automatic test_illegal_force();
    force_en     = 1'b1;
    force_dev_id = 4'h6;
    tick();
    checks++;
    if (err_force_illegal !== 1'b1 || bus.fw_dev_id_enable !== 4'h0 || arb_state !== 2'd0) begin
      errors++;
      $display("FAIL ill_detect err=%b en=%h st=%0d expected err=1 en=0 st=0",
               err_force_illegal, bus.fw_dev_id_enable, arb_state);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++;
    if (err_force_illegal !== 1'b1) begin
      errors++;
      $display("FAIL ill_set_wins err=%b expected=1", err_force_illegal);
    end
    force_dev_id = 4'h2;
    tick();
    exp_sw++;
    checks++;
    if (bus.fw_dev_id_enable !== 4'h2 || err_force_illegal !== 1'b1) begin
      errors++;
      $display("FAIL ill_legal_grant en=%h err=%b expected en=2 err=1", bus.fw_dev_id_enable, err_force_illegal);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++;
    if (err_force_illegal !== 1'b0 || bus.fw_dev_id_enable !== 4'h2) begin
      errors++;
      $display("FAIL ill_clear err=%b en=%h expected err=0 en=2", err_force_illegal, bus.fw_dev_id_enable);
    end
    force_en     = 1'b0;
    force_dev_id = 4'h0;
    tick();
    wait_idle("ill");
  endtask

  task automatic test_reset_mid_grant();
    force_en     = 1'b1;
    force_dev_id = 4'h3;
    tick();
    force_en     = 1'b0;
    force_dev_id = 4'h0;
    bus.fw_req   = 4'h2;
    tick();
    checks++;
    if (bus.fw_dev_id_enable !== 4'h2 || err_force_illegal !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_grant en=%h err=%b expected en=2 err=1", bus.fw_dev_id_enable, err_force_illegal);
    end
    #2;
    iob_reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.fw_dev_id_enable, bus.fw_grant, arb_state, err_force_illegal, switch_count} !== 27'd0) begin
      errors++;
      $display("FAIL rst_async en=%h gnt=%h st=%0d err=%b cnt=%0d expected all zero",
               bus.fw_dev_id_enable, bus.fw_grant, arb_state, err_force_illegal, switch_count);
    end
    bus.fw_req = 4'hF;
    @(negedge iob_clk);
    iob_reset_n = 1'b1;
    exp_sw = 0;
    tick();
    exp_sw++;
    checks++;
    if (bus.fw_dev_id_enable !== 4'h1 || switch_count !== 16'(exp_sw)) begin
      errors++;
      $display("FAIL rst_fw0_first en=%h cnt=%0d expected en=1 cnt=%0d", bus.fw_dev_id_enable, switch_count, exp_sw);
    end
    bus.fw_req = 4'h0;
    tick();
    wait_idle("rst");
  endtask

  task automatic test_counter_wrap();
    force dut.switch_count = 16'hFFFF;
    #1;
    release dut.switch_count;
    bus.fw_req = 4'h4;
    tick();
    checks++;
    if (switch_count !== 16'h0000 || bus.fw_dev_id_enable !== 4'h4) begin
      errors++;
      $display("FAIL wrap_to_zero cnt=%h en=%h expected cnt=0000 en=4", switch_count, bus.fw_dev_id_enable);
    end
    bus.fw_req = 4'h0;
    tick();
    wait_idle("wrap");
    bus.fw_req = 4'h8;
    tick();
    checks++;
    if (switch_count !== 16'h0001 || bus.fw_dev_id_enable !== 4'h8) begin
      errors++;
      $display("FAIL wrap_next cnt=%h en=%h expected cnt=0001 en=8", switch_count, bus.fw_dev_id_enable);
    end
    bus.fw_req = 4'h0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_single_request();
    test_force_preempt();
    test_illegal_force();
    test_reset_mid_grant();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
